// File: rtl/multilevel_xnor_mac.sv
// Multi-level binarised XNOR-popcount MAC: per-level gamma-scaled bipolar dot products,
// folded over FOLD beats and scaled by the layer gamma into one saturated result per neuron.
module multilevel_xnor_mac #(
    parameter int SIMD          = 32,
    parameter int WEIGHT_LEVELS = 2,
    parameter int TWIDTH        = 24,
    parameter int FRAC          = 8,
    parameter int FOLD          = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SIMD-1:0]                 in_act,
    input  logic [SIMD*WEIGHT_LEVELS-1:0]   in_weight,
    input  logic [TWIDTH*WEIGHT_LEVELS-1:0] weight_gamma,
    input  logic [TWIDTH-1:0]               layer_gamma,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [TWIDTH-1:0]               out_data,
    output logic                            out_sat
);

    localparam int PCW = $clog2(SIMD + 1);
    localparam int BW  = PCW + 2;
    localparam int SW  = TWIDTH + BW + $clog2(WEIGHT_LEVELS) + 1;
    localparam int MW  = ((2 * TWIDTH > SW) ? 2 * TWIDTH : SW) + 1;
    localparam int CW  = (FOLD > 1) ? $clog2(FOLD) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(FOLD - 1);

    typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_SCALE, ST_HOLD} state_t;

    // Returns {saturated, value}; every saturation point goes through here so the flag is uniform.
    function automatic logic [TWIDTH:0] sat_fn(input logic signed [MW-1:0] x);
        logic signed [MW-1:0] max_v;
        logic signed [MW-1:0] min_v;
        max_v = {{(MW - TWIDTH + 1){1'b0}}, {(TWIDTH - 1){1'b1}}};
        min_v = {{(MW - TWIDTH + 1){1'b1}}, {(TWIDTH - 1){1'b0}}};
        if (x > max_v) return {1'b1, max_v[TWIDTH-1:0]};
        if (x < min_v) return {1'b1, min_v[TWIDTH-1:0]};
        return {1'b0, x[TWIDTH-1:0]};
    endfunction

    state_t                   r_state;
    state_t                   w_next_state;
    logic [CW-1:0]            r_count;
    logic signed [TWIDTH-1:0] r_pipe;
    logic signed [TWIDTH-1:0] r_acc;
    logic                     r_pipe_valid;
    logic                     r_sat_flag;
    logic                     r_out_valid;
    logic                     r_out_sat;
    logic [TWIDTH-1:0]        r_out_data;

    logic                     w_in_ready;
    logic                     w_accept;
    logic [PCW-1:0]           w_pc  [WEIGHT_LEVELS];
    logic signed [BW-1:0]     w_bip [WEIGHT_LEVELS];
    logic signed [SW-1:0]     w_sum;
    logic signed [SW-1:0]     w_sum_shift;
    logic signed [MW-1:0]     w_prod;
    logic [TWIDTH:0]          w_beat_sat;
    logic [TWIDTH:0]          w_acc_sat;
    logic [TWIDTH:0]          w_final_sat;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_sum = '0;
        for (int l = 0; l < WEIGHT_LEVELS; l++) begin
            w_pc[l] = '0;
            for (int i = 0; i < SIMD; i++) begin
                w_pc[l] = w_pc[l] + PCW'(in_act[i] ~^ in_weight[l*SIMD+i]);
            end
            w_bip[l] = $signed({1'b0, w_pc[l], 1'b0}) - $signed(BW'(SIMD));
            w_sum    = w_sum + SW'(w_bip[l]) * SW'($signed(weight_gamma[l*TWIDTH +: TWIDTH]));
        end
    end

    assign w_sum_shift = w_sum >>> FRAC;
    assign w_beat_sat  = sat_fn(MW'(w_sum_shift));
    assign w_acc_sat   = sat_fn(MW'(r_acc) + MW'(r_pipe));
    assign w_prod      = MW'(r_acc) * MW'($signed(layer_gamma));
    assign w_final_sat = sat_fn(w_prod >>> FRAC);

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_ready = 1'b1;
                if (in_valid && (r_count == LAST_BEAT)) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: if (r_pipe_valid) w_next_state = ST_SCALE;
            ST_SCALE: w_next_state = ST_HOLD;
            ST_HOLD:  if (out_ready) w_next_state = ST_ACC;
            default:  w_next_state = ST_ACC;
        endcase
    end

    assign w_accept = in_valid && w_in_ready;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ACC;
            r_count      <= '0;
            r_pipe       <= '0;
            r_pipe_valid <= 1'b0;
            r_acc        <= '0;
            r_sat_flag   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sat    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_pipe_valid <= w_accept;
            if (w_accept) begin
                r_pipe  <= w_beat_sat[TWIDTH-1:0];
                r_count <= (r_count == LAST_BEAT) ? '0 : r_count + 1'b1;
            end
            if (r_pipe_valid) r_acc <= w_acc_sat[TWIDTH-1:0];
            if (r_state == ST_SCALE) begin
                r_out_data  <= w_final_sat[TWIDTH-1:0];
                r_out_sat   <= r_sat_flag | w_final_sat[TWIDTH];
                r_out_valid <= 1'b1;
            end
            // Result consumed: clear everything that belongs to this neuron.
            if (r_state == ST_HOLD && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_sat   <= 1'b0;
                r_acc       <= '0;
                r_sat_flag  <= 1'b0;
            end else begin
                r_sat_flag <= r_sat_flag | (w_accept & w_beat_sat[TWIDTH])
                                         | (r_pipe_valid & w_acc_sat[TWIDTH]);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule
